// File: rtl/vec_store_serializer_pkg.sv
// vec_store_serializer_pkg: shared widths and FSM state type for the store serializer.
package vec_store_serializer_pkg;
  localparam int V = 192;
  localparam int S = 32;
  localparam int LANES = 6;
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_e;
endpackage

// File: rtl/vec_store_serializer.sv
// vec_store_serializer: captures a lane vector and writes it to memory one word per lane.
module vec_store_serializer #(
  parameter int V = vec_store_serializer_pkg::V,
  parameter int S = vec_store_serializer_pkg::S,
  parameter int LANES = vec_store_serializer_pkg::LANES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_op,
  input  logic [V-1:0]  in_data,
  input  logic          in_flagZ,
  input  logic [31:0]   in_addr,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [S-1:0]  mem_wdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          done,
  output logic          flagZ_q
);
  import vec_store_serializer_pkg::*;
  localparam int CW = LANES > 1 ? $clog2(LANES) : 1;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [V-1:0] data_q, data_d;
  logic [31:0] base_q, base_d;
  logic op_q, op_d, flagz_d, fire, last;
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign mem_we    = state_q == WRITE;
  assign done      = state_q == DONE;
  assign mem_addr  = base_q + (32'(cnt_q) << 2);
  assign mem_wdata = data_q[S*cnt_q +: S];
  assign fire      = mem_we && mem_ready;
  // scalar stores finish on lane 0; the counter never steps past the last lane
  assign last      = op_q ? cnt_q == CW'(LANES-1) : 1'b1;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    base_d  = base_q;
    op_d    = op_q;
    flagz_d = flagZ_q;
    if (state_q == IDLE && in_valid) begin
      state_d = WRITE;
      cnt_d   = '0;
      data_d  = in_data;
      base_d  = in_addr;
      op_d    = in_op;
      flagz_d = in_flagZ;
    end
    if (fire) begin
      cnt_d   = last ? cnt_q : cnt_q + CW'(1);
      state_d = last ? DONE : WRITE;
    end
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      base_q  <= '0;
      op_q    <= 1'b0;
      flagZ_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      base_q  <= base_d;
      op_q    <= op_d;
      flagZ_q <= flagz_d;
    end
  end
endmodule
